// File: rtl/maze_pkg.sv
// Shared maze definitions: level map, heading bit positions and
// the move-checker state encoding.
package maze_pkg;

    localparam int DIR_L = 0;
    localparam int DIR_R = 1;
    localparam int DIR_U = 2;
    localparam int DIR_D = 3;

    // Tile t = r*8+c sits at nibble t; the rightmost hex digit is tile 0.
    localparam logic [255:0] LEVEL1_GRID =
        256'hA3C5_96FF_0E1B_7D24_5A69_C3F0_8E17_B2D4_6F91_3AC8_E075_D2B6_1F4A_9C3E_7B58_20D6;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        LOOKUP,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with one-hot grant; the search starts at the
// pointer, which advances past the winner on accept.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          accept,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr;
    logic          found;
    int            j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept && found) begin
            if (int'(gnt_idx) == N - 1) ptr <= '0;
            else ptr <= gnt_idx + IW'(1);
        end
    end

endmodule

// File: rtl/maze_move_checker.sv
// Arbitrated sprite-position to maze-tile legal-move lookup with a
// runtime-writable map grid.
module maze_move_checker
    import maze_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int COLS    = 8,
    parameter int ROWS    = 8,
    parameter int TILE    = 60,
    parameter int ORG_X   = 150,
    parameter int ORG_Y   = 34,
    parameter int LOOK    = 20,
    parameter int COORD_W = 10,
    parameter logic [COLS*ROWS*4-1:0] GRID = LEVEL1_GRID
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH-1:0]              req_valid,
    output logic [NUM_CH-1:0]              req_ready,
    input  logic [NUM_CH*COORD_W-1:0]      req_x,
    input  logic [NUM_CH*COORD_W-1:0]      req_y,
    input  logic [NUM_CH*4-1:0]            req_dir,
    input  logic                           wr_en,
    input  logic [$clog2(ROWS*COLS)-1:0]   wr_addr,
    input  logic [3:0]                     wr_data,
    output logic                           rsp_valid,
    output logic [$clog2(NUM_CH)-1:0]      rsp_ch,
    output logic [3:0]                     rsp_legal,
    output logic [$clog2(ROWS):0]          rsp_row,
    output logic [$clog2(COLS):0]          rsp_col,
    output logic                           rsp_oob,
    output logic                           busy
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int A_W  = $clog2(ROWS*COLS);
    localparam int R_W  = $clog2(ROWS) + 1;
    localparam int C_W  = $clog2(COLS) + 1;
    localparam int CW   = COORD_W + 2;

    localparam logic signed [CW-1:0] TILE_S = CW'(TILE);
    localparam logic signed [CW-1:0] LOOK_S = CW'(LOOK);
    localparam logic signed [CW-1:0] OX_S   = CW'(ORG_X);
    localparam logic signed [CW-1:0] OY_S   = CW'(ORG_Y);
    localparam logic [C_W-1:0]       COLS_V = C_W'(COLS);
    localparam logic [R_W-1:0]       ROWS_V = R_W'(ROWS);

    state_t state, state_nxt;

    logic [NUM_CH-1:0]       gnt;
    logic [CH_W-1:0]         gnt_idx;
    logic                    accept;
    logic [COORD_W-1:0]      sel_x, sel_y;
    logic [3:0]              sel_dir;
    logic signed [CW-1:0]    px, py, rx, ry;
    logic signed [CW-1:0]    rem_x, rem_y;
    logic [C_W-1:0]          col;
    logic [R_W-1:0]          row;
    logic [CH_W-1:0]         ch_q;
    logic                    oob_q;
    logic [3:0]              legal_q;
    logic                    step_x, step_y, lk_oob;
    logic [A_W-1:0]          rd_idx;
    logic [ROWS*COLS*4-1:0]  grid;

    rr_arbiter #(
        .N  (NUM_CH),
        .IW (CH_W)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .accept  (state == IDLE),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign accept    = (state == IDLE) && (|req_valid);
    assign req_ready = (state == IDLE) ? gnt : '0;
    assign busy      = (state != IDLE);

    assign sel_x   = req_x[gnt_idx*COORD_W +: COORD_W];
    assign sel_y   = req_y[gnt_idx*COORD_W +: COORD_W];
    assign sel_dir = req_dir[gnt_idx*4 +: 4];

    // Look-ahead probe, one axis moved by the highest-priority heading.
    always_comb begin
        px = $signed({2'b00, sel_x});
        py = $signed({2'b00, sel_y});
        if (sel_dir[DIR_L])      px = px - LOOK_S;
        else if (sel_dir[DIR_R]) px = px + LOOK_S;
        else if (sel_dir[DIR_U]) py = py - LOOK_S;
        else if (sel_dir[DIR_D]) py = py + LOOK_S;
        rx = px - OX_S;
        ry = py - OY_S;
    end

    assign step_x = !oob_q && (rem_x >= TILE_S) && (col < COLS_V);
    assign step_y = !oob_q && (rem_y >= TILE_S) && (row < ROWS_V);
    assign lk_oob = oob_q || (col >= COLS_V) || (row >= ROWS_V);
    assign rd_idx = A_W'(int'(row) * COLS + int'(col));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (|req_valid) state_nxt = DIV;
            DIV:     if (!step_x && !step_y) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q      <= '0;
            rem_x     <= '0;
            rem_y     <= '0;
            col       <= '0;
            row       <= '0;
            oob_q     <= 1'b0;
            legal_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_ch    <= '0;
            rsp_legal <= '0;
            rsp_row   <= '0;
            rsp_col   <= '0;
            rsp_oob   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                ch_q  <= gnt_idx;
                rem_x <= rx;
                rem_y <= ry;
                col   <= '0;
                row   <= '0;
                oob_q <= rx[CW-1] | ry[CW-1];
            end
            if (state == DIV) begin
                if (step_x) begin
                    rem_x <= rem_x - TILE_S;
                    col   <= col + C_W'(1);
                end
                if (step_y) begin
                    rem_y <= rem_y - TILE_S;
                    row   <= row + R_W'(1);
                end
            end
            if (state == LOOKUP) begin
                oob_q   <= lk_oob;
                legal_q <= lk_oob ? 4'b0000 : grid[{rd_idx, 2'b00} +: 4];
            end
            if (state == RESP) begin
                rsp_valid <= 1'b1;
                rsp_ch    <= ch_q;
                rsp_legal <= legal_q;
                rsp_row   <= row;
                rsp_col   <= col;
                rsp_oob   <= oob_q;
            end
        end
    end

    // Reads in LOOKUP see the grid before a same-cycle write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grid <= GRID;
        end else if (wr_en && (int'(wr_addr) < ROWS*COLS)) begin
            grid[{wr_addr, 2'b00} +: 4] <= wr_data;
        end
    end

endmodule
